serial_add_ctrl: RTL and testbench

//  Bit-serial sequencer wrapped around the registered 1-bit full adder (fa).

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/serial_add_sipo.sv | 27 ++
 rtl/serial_add_ctrl.sv | 147 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder sequencer.
package serial_add_pkg;

    localparam int unsigned DEF_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_sipo.sv
// W-bit right-shift capture register: new bits enter at the MSB, clear has priority.
module serial_add_sipo #(
    parameter int unsigned W = 8
) (
    input  logic         ck,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_bit,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= {i_bit, r_q[W-1:1]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer around an external registered 1-bit full adder.
// Define SERIAL_ADD_SUB_EN to add the in_sub port (two's-complement subtract).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         ck,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_ci,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         in_sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_co,
    output logic         fa_a,
    output logic         fa_b,
    output logic         fa_ci,
    input  logic         fa_s,
    input  logic         fa_co
);

    localparam int unsigned CNT_W = cnt_width(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_a_sh;
    logic [W-1:0]     r_b_sh;
    logic             r_ci0;
    logic             r_co;

    logic             w_load;
    logic             w_run;
    logic             w_sum_en;
    logic             w_co_ld;
    logic [W-1:0]     w_b_in;
    logic             w_ci_in;

`ifdef SERIAL_ADD_SUB_EN
    // Subtract as a + ~b + 1; out_co=1 then means no borrow.
    assign w_b_in  = in_sub ? ~in_b : in_b;
    assign w_ci_in = in_sub ? 1'b1 : in_ci;
`else
    assign w_b_in  = in_b;
    assign w_ci_in = in_ci;
`endif

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_run     = 1'b0;
        w_sum_en  = 1'b0;
        w_co_ld   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_ci     = 1'b0;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load    = 1'b1;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_run = 1'b1;
                fa_a  = r_a_sh[0];
                fa_b  = r_b_sh[0];
                // Bit 0 never sees a stale carry from the previous word.
                fa_ci = (r_cnt == '0) ? r_ci0 : fa_co;
                // fa output lags one cycle, so capture starts at bit 1.
                w_sum_en = (r_cnt != '0);
                if (r_cnt == CNT_LAST) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                w_sum_en  = 1'b1;
                w_co_ld   = 1'b1;
                w_state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_ci0  <= 1'b0;
            r_co   <= 1'b0;
        end else begin
            if (w_load) begin
                r_a_sh <= in_a;
                r_b_sh <= w_b_in;
                r_ci0  <= w_ci_in;
                r_cnt  <= '0;
            end else if (w_run) begin
                r_a_sh <= {1'b0, r_a_sh[W-1:1]};
                r_b_sh <= {1'b0, r_b_sh[W-1:1]};
                r_cnt  <= r_cnt + CNT_W'(1);
            end
            if (w_co_ld) begin
                r_co <= fa_co;
            end
        end
    end

    serial_add_sipo #(
        .W (W)
    ) u_sum_sh (
        .ck    (ck),
        .rst_n (rst_n),
        .i_clr (w_load),
        .i_en  (w_sum_en),
        .i_bit (fa_s),
        .o_q   (out_sum)
    );

    assign out_co = r_co;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (W=8) with a behavioural registered full adder.
// Define SERIAL_ADD_SUB_EN to also exercise the subtract vectors.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         ck = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_ci;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_co;
    logic         fa_a;
    logic         fa_b;
    logic         fa_ci;
    logic         fa_s = 1'b0;
    logic         fa_co = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 ck = ~ck;

    // Registered full adder, its sync reset tied low.
    always @(posedge ck) begin
        {fa_co, fa_s} <= {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_ci};
    end

    serial_add_ctrl #(
        .W (W)
    ) dut (
        .ck        (ck),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
`ifdef SERIAL_ADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_ci     (fa_ci),
        .fa_s      (fa_s),
        .fa_co     (fa_co)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_co;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Offer one word, wait for out_valid; leaves the DUT in DONE with out_ready=0.
    task automatic start_and_wait(input vec_t v, output int lat, output logic ok);
        @(negedge ck);
        in_a     = v.a;
        in_b     = v.b;
        in_ci    = v.ci;
        in_sub   = v.sub;
        in_valid = 1'b1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge ck);
        #1;
        in_valid = 1'b0;
        lat = 0;
        ok  = 1'b0;
        while (lat < 20) begin
            @(posedge ck);
            lat++;
            #1;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("out_valid_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic release_done();
        @(negedge ck);
        out_ready = 1'b1;
        @(posedge ck);
        #1;
        out_ready = 1'b0;
        check("idle_after_ready_in_ready", 32'(in_ready), 32'd1);
        check("idle_after_ready_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int   lat;
        logic ok;
        logic [W-1:0] held_sum;
        logic         held_co;
        vec_t v;

        vecs.push_back('{a: 8'h5A, b: 8'h33, ci: 1'b0, sub: 1'b0, exp_sum: 8'h8D, exp_co: 1'b0});
        vecs.push_back('{a: 8'hFF, b: 8'h01, ci: 1'b0, sub: 1'b0, exp_sum: 8'h00, exp_co: 1'b1});
        vecs.push_back('{a: 8'hFF, b: 8'h00, ci: 1'b1, sub: 1'b0, exp_sum: 8'h00, exp_co: 1'b1});
        vecs.push_back('{a: 8'h80, b: 8'h80, ci: 1'b0, sub: 1'b0, exp_sum: 8'h00, exp_co: 1'b1});
        vecs.push_back('{a: 8'h12, b: 8'h34, ci: 1'b1, sub: 1'b0, exp_sum: 8'h47, exp_co: 1'b0});
        vecs.push_back('{a: 8'hAA, b: 8'h55, ci: 1'b0, sub: 1'b0, exp_sum: 8'hFF, exp_co: 1'b0});
        vecs.push_back('{a: 8'hFF, b: 8'hFF, ci: 1'b1, sub: 1'b0, exp_sum: 8'hFF, exp_co: 1'b1});
        vecs.push_back('{a: 8'h00, b: 8'h00, ci: 1'b0, sub: 1'b0, exp_sum: 8'h00, exp_co: 1'b0});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{a: 8'h10, b: 8'h01, ci: 1'b0, sub: 1'b1, exp_sum: 8'h0F, exp_co: 1'b1});
        vecs.push_back('{a: 8'h00, b: 8'h01, ci: 1'b0, sub: 1'b1, exp_sum: 8'hFF, exp_co: 1'b0});
        vecs.push_back('{a: 8'h10, b: 8'h01, ci: 1'b0, sub: 1'b0, exp_sum: 8'h11, exp_co: 1'b0});
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_ci     = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge ck);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'h00);
        check("rst_out_co", 32'(out_co), 32'd0);
        check("rst_fa_pins", 32'({fa_a, fa_b, fa_ci}), 32'd0);
        @(negedge ck);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            start_and_wait(vecs[i], lat, ok);
            if (ok) begin
                check($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
                check($sformatf("vec%0d_sum", i), 32'(out_sum), 32'(vecs[i].exp_sum));
                check($sformatf("vec%0d_co", i), 32'(out_co), 32'(vecs[i].exp_co));
                check($sformatf("vec%0d_done_fa_pins", i), 32'({fa_a, fa_b, fa_ci}), 32'd0);
            end
            release_done();
        end

        // Backpressure: hold DONE for 5 clocks, an in_valid pulse must be ignored.
        v = '{a: 8'h5A, b: 8'h33, ci: 1'b0, sub: 1'b0, exp_sum: 8'h8D, exp_co: 1'b0};
        start_and_wait(v, lat, ok);
        held_sum = 8'h8D;
        held_co  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge ck);
            if (k == 2) begin
                in_a     = 8'h01;
                in_b     = 8'h02;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge ck);
            #1;
            check($sformatf("bp%0d_sum", k), 32'(out_sum), 32'(held_sum));
            check($sformatf("bp%0d_co", k), 32'(out_co), 32'(held_co));
            check($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_done();

        // Mid-word reset at cnt=3 discards the word.
        @(negedge ck);
        in_a     = 8'hF0;
        in_b     = 8'h0F;
        in_ci    = 1'b1;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        @(posedge ck);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge ck);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sum", 32'(out_sum), 32'h00);
        check("midrst_fa_pins", 32'({fa_a, fa_b, fa_ci}), 32'd0);
        @(negedge ck);
        rst_n = 1'b1;
        v = '{a: 8'h01, b: 8'h01, ci: 1'b0, sub: 1'b0, exp_sum: 8'h02, exp_co: 1'b0};
        start_and_wait(v, lat, ok);
        if (ok) begin
            check("postrst_latency", 32'(lat), 32'd9);
            check("postrst_sum", 32'(out_sum), 32'h02);
            check("postrst_co", 32'(out_co), 32'd0);
        end
        release_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
